// File: rtl/uart8_receiver.sv
// 8-bit UART receiver: 2-flop line synchroniser, 3-sample majority vote around
// mid-bit, one-cycle done strobe with a framing-error flag.
module uart8_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] out
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] CNT_PRE  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(M);
    localparam logic [CW-1:0] CNT_POST = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] RESET      = 3'd0;
    localparam logic [2:0] IDLE       = 3'd1;
    localparam logic [2:0] START_BIT  = 3'd2;
    localparam logic [2:0] DATA_BITS  = 3'd3;
    localparam logic [2:0] STOP_BIT   = 3'd4;
    localparam logic [2:0] BREAK_WAIT = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sync1;
    logic          in_sync;
    logic          samp_a;
    logic          samp_b;
    logic          majority;

    // Synchroniser resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            in_sync <= 1'b1;
        end else begin
            sync1   <= in;
            in_sync <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (cnt == CNT_PRE) samp_a <= in_sync;
            if (cnt == CNT_MID) samp_b <= in_sync;
        end
    end

    // Third vote is the live synchronised sample taken at cnt = M+1.
    assign majority = (samp_a & samp_b) | (samp_a & in_sync) | (samp_b & in_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            out     <= 8'h00;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            done <= 1'b0;
            if (state != RESET && !en) begin
                state <= RESET;
            end else begin
                case (state)
                    RESET: begin
                        busy    <= 1'b0;
                        err     <= 1'b0;
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        if (en) state <= IDLE;
                    end
                    IDLE: begin
                        if (!in_sync) begin
                            state <= START_BIT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START_BIT: begin
                        if (cnt == CNT_POST && majority) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= DATA_BITS;
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA_BITS: begin
                        if (cnt == CNT_POST) shift[bit_idx] <= majority;
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= STOP_BIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP_BIT: begin
                        // Leave at mid stop bit so a fast transmitter's next start edge is not missed.
                        if (cnt == CNT_POST) begin
                            out   <= shift;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            err   <= ~majority;
                            state <= majority ? IDLE : BREAK_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BREAK_WAIT: begin
                        if (in_sync) state <= IDLE;
                    end
                    default: state <= RESET;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart8_receiver.sv
// Directed bench for uart8_receiver: a time-indexed frame model is compared with
// the outputs every cycle, plus literal checks of received bytes and latency.
module tb_uart8_receiver;
    localparam int OS = 16;
    localparam int M  = OS / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       in    = 1'b1;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] out;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    bit cmp_on    = 1'b0;

    logic [7:0] got_q[$];
    logic       err_q[$];

    uart8_receiver #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {M_RESET, M_IDLE, M_FRAME, M_BREAK} mode_t;

    mode_t      mode   = M_RESET;
    logic [4:0] hist   = 5'b11111;
    int         tm     = 0;
    int         fstart = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_out  = 8'h00;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;

    // hist[k] is the line as sampled k edges ago; decisions see the line two edges late.
    always @(posedge clk or negedge rst_n) begin : model
        int   d;
        int   b;
        int   c;
        logic maj;
        if (!rst_n) begin
            mode   = M_RESET;
            hist   = 5'b11111;
            m_byte = 8'h00;
            m_out  = 8'h00;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            tm++;
            hist   = {hist[3:0], in};
            maj    = (int'(hist[4]) + int'(hist[3]) + int'(hist[2])) >= 2;
            m_done = 1'b0;
            if (mode == M_RESET) begin
                m_busy = 1'b0;
                m_err  = 1'b0;
                if (en) mode = M_IDLE;
            end else if (!en) begin
                mode = M_RESET;
            end else if (mode == M_IDLE) begin
                if (!hist[2]) begin
                    mode   = M_FRAME;
                    fstart = tm;
                    m_busy = 1'b1;
                end
            end else if (mode == M_BREAK) begin
                if (hist[2]) mode = M_IDLE;
            end else begin
                d = tm - fstart - 1;
                b = d / OS;
                c = d % OS;
                if (c == M + 1) begin
                    if (b == 0) begin
                        if (maj) begin
                            mode   = M_IDLE;
                            m_busy = 1'b0;
                        end
                    end else if (b <= 8) begin
                        m_byte[b-1] = maj;
                    end else begin
                        m_out  = m_byte;
                        m_done = 1'b1;
                        m_busy = 1'b0;
                        m_err  = !maj;
                        mode   = maj ? M_IDLE : M_BREAK;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%02h, expected 'h%02h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("busy", 8'(busy), 8'(m_busy));
            check_output("done", 8'(done), 8'(m_done));
            check_output("err", 8'(err), 8'(m_err));
            check_output("out", out, m_out);
            check_output("busy_and_done", 8'(busy & done), 8'h00);
        end
        if (done) begin
            got_q.push_back(out);
            err_q.push_back(err);
            done_cyc = cyc;
        end
    end

    // alt stretches odd-numbered bits by one clock, giving a fractional bit period.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_v, input int base_len, input bit alt);
        logic [9:0] frame;
        frame     = {stop_v, data, 1'b0};
        start_cyc = cyc + 1;
        for (int b = 0; b < 10; b++) begin
            in = frame[b];
            repeat (base_len + ((alt && (b % 2 == 1)) ? 1 : 0)) @(negedge clk);
        end
    endtask

    task automatic idle_line(input int n);
        in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_last(input string name, input int n0, input int n_exp,
                              input logic [7:0] exp_byte, input logic exp_err);
        check_output({name, "_count"}, 8'(got_q.size() - n0), 8'(n_exp));
        check_output({name, "_byte"}, got_q[$], exp_byte);
        check_output({name, "_err"}, 8'(err_q[$]), 8'(exp_err));
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 8'(busy), 8'h00);
        check_output("rst_done", 8'(done), 8'h00);
        check_output("rst_err", 8'(err), 8'h00);
        check_output("rst_out", out, 8'h00);
        cmp_on = 1'b1;
        rst_n  = 1'b1;
        en     = 1'b1;
        idle_line(10);

        n0 = got_q.size();
        apply_stimulus(8'hA5, 1'b1, 16, 1'b0);
        check_output("a5_latency", 8'(done_cyc - start_cyc), 8'd156);
        idle_line(20);
        check_last("a5", n0, 1, 8'hA5, 1'b0);

        n0 = got_q.size();
        in = 1'b0;
        repeat (4) @(negedge clk);
        idle_line(40);
        check_output("glitch_count", 8'(got_q.size() - n0), 8'd0);
        apply_stimulus(8'h3C, 1'b1, 16, 1'b0);
        idle_line(20);
        check_last("x3c", n0, 1, 8'h3C, 1'b0);

        n0 = got_q.size();
        apply_stimulus(8'h81, 1'b0, 16, 1'b0);
        in = 1'b0;
        repeat (40 * OS) @(negedge clk);
        idle_line(40);
        check_last("x81_break", n0, 1, 8'h81, 1'b1);
        n0 = got_q.size();
        apply_stimulus(8'h55, 1'b1, 16, 1'b0);
        idle_line(20);
        check_last("x55", n0, 1, 8'h55, 1'b0);

        n0 = got_q.size();
        apply_stimulus(8'h00, 1'b1, 17, 1'b0);
        apply_stimulus(8'hFF, 1'b1, 17, 1'b0);
        idle_line(30);
        check_last("slow_ff", n0, 2, 8'hFF, 1'b0);
        check_output("slow_00_byte", got_q[$-1], 8'h00);
        check_output("slow_00_err", 8'(err_q[$-1]), 8'h00);

        // A uniform 15-clk bit drifts past the mid-stop sample, so fast uses 15/16 alternation.
        n0 = got_q.size();
        apply_stimulus(8'h00, 1'b1, 15, 1'b1);
        apply_stimulus(8'hFF, 1'b1, 15, 1'b1);
        idle_line(30);
        check_last("fast_ff", n0, 2, 8'hFF, 1'b0);
        check_output("fast_00_byte", got_q[$-1], 8'h00);
        check_output("fast_00_err", 8'(err_q[$-1]), 8'h00);

        n0 = got_q.size();
        fork
            apply_stimulus(8'hF0, 1'b1, 16, 1'b0);
            begin
                repeat (88) @(negedge clk);
                en = 1'b0;
                repeat (3) @(negedge clk);
                en = 1'b1;
            end
        join
        idle_line(30);
        check_output("en_abort_count", 8'(got_q.size() - n0), 8'd0);
        apply_stimulus(8'h69, 1'b1, 16, 1'b0);
        idle_line(20);
        check_last("x69", n0, 1, 8'h69, 1'b0);

        n0 = got_q.size();
        fork
            apply_stimulus(8'h99, 1'b1, 16, 1'b0);
            begin
                repeat (150) @(negedge clk);
                #3 rst_n = 1'b0;
                #1;
                check_output("arst_busy", 8'(busy), 8'h00);
                check_output("arst_done", 8'(done), 8'h00);
                check_output("arst_err", 8'(err), 8'h00);
                check_output("arst_out", out, 8'h00);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        join
        idle_line(30);
        check_output("arst_count", 8'(got_q.size() - n0), 8'd0);
        apply_stimulus(8'hC3, 1'b1, 16, 1'b0);
        idle_line(20);
        check_last("xc3", n0, 1, 8'hC3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
